// File: rtl/taxi_eth_link_mon_if.sv
// rtl/taxi_eth_link_mon_if.sv - per-channel PCS status inputs and link monitor outputs
interface taxi_eth_link_mon_if #(
  parameter int CNT        = 4,
  parameter int FLAP_CNT_W = 16,
  parameter int ERR_CNT_W  = 32
);
  logic [CNT-1:0]                 rx_block_lock;
  logic [CNT-1:0]                 rx_high_ber;
  logic [CNT-1:0]                 rx_status;
  logic [CNT-1:0][6:0]            rx_error_count;
  logic [CNT-1:0]                 cfg_enable;
  logic [CNT-1:0]                 clear_req;
  logic [CNT-1:0]                 irq_ack;
  logic [CNT-1:0]                 link_up;
  logic [CNT-1:0][1:0]            link_state;
  logic [CNT-1:0][FLAP_CNT_W-1:0] link_down_cnt;
  logic [CNT-1:0][ERR_CNT_W-1:0]  err_accum;
  logic [CNT-1:0]                 irq_status;
  logic                           irq;

  modport master (
    output rx_block_lock, rx_high_ber, rx_status, rx_error_count,
    output cfg_enable, clear_req, irq_ack,
    input  link_up, link_state, link_down_cnt, err_accum, irq_status, irq
  );

  modport slave (
    input  rx_block_lock, rx_high_ber, rx_status, rx_error_count,
    input  cfg_enable, clear_req, irq_ack,
    output link_up, link_state, link_down_cnt, err_accum, irq_status, irq
  );
endinterface

// File: rtl/taxi_eth_link_mon.sv
// rtl/taxi_eth_link_mon.sv - debounced per-channel link state, flap/error counters, sticky irq
module taxi_eth_link_mon #(
  parameter int CNT        = 4,
  parameter int UP_DELAY   = 1024,
  parameter int DOWN_DELAY = 4,
  parameter int FLAP_CNT_W = 16,
  parameter int ERR_CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  taxi_eth_link_mon_if.slave    bus
);
  localparam int MAX_DELAY = (UP_DELAY > DOWN_DELAY) ? UP_DELAY : DOWN_DELAY;
  localparam int TW        = $clog2(MAX_DELAY + 1);
  localparam int AW        = ERR_CNT_W + 1;

  localparam logic [1:0] ST_DOWN   = 2'd0;
  localparam logic [1:0] ST_ARMING = 2'd1;
  localparam logic [1:0] ST_UP     = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam logic [TW-1:0]         UP_T     = TW'(UP_DELAY);
  localparam logic [TW-1:0]         DOWN_T   = TW'(DOWN_DELAY);
  localparam logic [FLAP_CNT_W-1:0] FLAP_MAX = '1;
  localparam logic [ERR_CNT_W-1:0]  ERR_MAX  = '1;

  logic [CNT-1:0] irq_vec;

  for (genvar i = 0; i < CNT; i++) begin : g_ch
    logic [1:0]            state;
    logic [TW-1:0]         timer;
    logic [FLAP_CNT_W-1:0] down_cnt;
    logic [ERR_CNT_W-1:0]  acc;
    logic                  irq_flag;
    logic                  good;
    logic                  up_evt;
    logic                  down_evt;
    logic [AW-1:0]         acc_sum;

    assign good = bus.rx_block_lock[i] & bus.rx_status[i] & ~bus.rx_high_ber[i] & bus.cfg_enable[i];

    // A disabled channel drops straight to DOWN and never raises an event.
    always_comb begin
      up_evt   = (state == ST_ARMING) && good && (timer == UP_T);
      down_evt = (state == ST_HOLD) && !good && bus.cfg_enable[i] && (timer == DOWN_T);
      acc_sum  = {1'b0, acc} + AW'(bus.rx_error_count[i]);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state    <= ST_DOWN;
        timer    <= '0;
        down_cnt <= '0;
        acc      <= '0;
        irq_flag <= 1'b0;
      end else begin
        if (!bus.cfg_enable[i]) begin
          state <= ST_DOWN;
          timer <= '0;
        end else begin
          case (state)
            ST_DOWN: begin
              if (good) begin
                state <= ST_ARMING;
                timer <= TW'(1);
              end
            end
            ST_ARMING: begin
              if (!good)
                state <= ST_DOWN;
              else if (timer == UP_T)
                state <= ST_UP;
              else
                timer <= timer + TW'(1);
            end
            ST_UP: begin
              if (!good) begin
                state <= ST_HOLD;
                timer <= TW'(1);
              end
            end
            default: begin
              if (good)
                state <= ST_UP;
              else if (timer == DOWN_T)
                state <= ST_DOWN;
              else
                timer <= timer + TW'(1);
            end
          endcase
        end

        if (bus.clear_req[i])
          down_cnt <= '0;
        else if (down_evt && (down_cnt != FLAP_MAX))
          down_cnt <= down_cnt + FLAP_CNT_W'(1);

        if (bus.clear_req[i])
          acc <= '0;
        else if (bus.cfg_enable[i])
          acc <= acc_sum[ERR_CNT_W] ? ERR_MAX : acc_sum[ERR_CNT_W-1:0];

        if (up_evt || down_evt)
          irq_flag <= 1'b1;
        else if (bus.irq_ack[i])
          irq_flag <= 1'b0;
      end
    end

    assign bus.link_state[i]    = state;
    assign bus.link_up[i]       = (state == ST_UP) || (state == ST_HOLD);
    assign bus.link_down_cnt[i] = down_cnt;
    assign bus.err_accum[i]     = acc;
    assign irq_vec[i]           = irq_flag;
  end

  assign bus.irq_status = irq_vec;
  assign bus.irq        = |irq_vec;
endmodule

// File: tb/tb_taxi_eth_link_mon.sv
// tb/tb_taxi_eth_link_mon.sv - scoreboard bench for taxi_eth_link_mon
module tb_taxi_eth_link_mon;
  localparam int CNT = 4;
  localparam int UPD = 16;
  localparam int DND = 4;
  localparam int FW  = 4;
  localparam int EW  = 8;

  localparam int K_UP  = 0;
  localparam int K_ST  = 1;
  localparam int K_CNT = 2;
  localparam int K_ERR = 3;
  localparam int K_IRQ = 4;
  localparam int K_ANY = 5;

  typedef struct {
    string  name;
    int     kind;
    int     ch;
    longint val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  taxi_eth_link_mon_if #(.CNT(CNT), .FLAP_CNT_W(FW), .ERR_CNT_W(EW)) bus ();

  taxi_eth_link_mon #(
    .CNT(CNT), .UP_DELAY(UPD), .DOWN_DELAY(DND), .FLAP_CNT_W(FW), .ERR_CNT_W(EW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic longint getval(int kind, int ch);
    case (kind)
      K_UP:    return longint'(bus.link_up[ch]);
      K_ST:    return longint'(bus.link_state[ch]);
      K_CNT:   return longint'(bus.link_down_cnt[ch]);
      K_ERR:   return longint'(bus.err_accum[ch]);
      K_IRQ:   return longint'(bus.irq_status[ch]);
      default: return longint'(bus.irq);
    endcase
  endfunction

  task automatic expect_val(string name, int kind, int ch, longint val);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.ch   = ch;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic expect_ch(string name, int ch, int up, int st, int cnt, int err, int irqs);
    expect_val({name, ".link_up"}, K_UP, ch, up);
    expect_val({name, ".state"}, K_ST, ch, st);
    expect_val({name, ".down_cnt"}, K_CNT, ch, cnt);
    expect_val({name, ".err_accum"}, K_ERR, ch, err);
    expect_val({name, ".irq_status"}, K_IRQ, ch, irqs);
  endtask

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: outputs are registered, so mid-cycle samples reflect the current state.
  initial begin
    exp_t e;
    longint v;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        v = getval(e.kind, e.ch);
        checks++;
        if (v == e.val)
          passed++;
        else
          $display("FAIL %s ch%0d got %0d expected %0d", e.name, e.ch, v, e.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic flap0(bit with_ack, int idx);
    bus.rx_block_lock[0] = 1'b0;
    step();
    if (with_ack) bus.irq_ack[0] = 1'b1;
    step();
    bus.irq_ack[0] = 1'b0;
    if (with_ack) expect_val("flap_ack_clears", K_IRQ, 0, 0);
    step(2);
    if (with_ack) bus.irq_ack[0] = 1'b1;
    step();
    bus.irq_ack[0] = 1'b0;
    expect_val("flap_down_state", K_ST, 0, 0);
    if (with_ack) expect_val("flap_set_beats_ack", K_IRQ, 0, 1);
    if (idx == 14 || with_ack) expect_val("flap_cnt_sat", K_CNT, 0, 15);
    bus.rx_block_lock[0] = 1'b1;
    step(17);
    expect_val("flap_rearm_up", K_UP, 0, 1);
  endtask

  initial begin
    rst                = 1'b1;
    bus.rx_block_lock  = '1;
    bus.rx_status      = '1;
    bus.rx_high_ber    = '0;
    bus.rx_error_count = '0;
    bus.cfg_enable     = '0;
    bus.clear_req      = '0;
    bus.irq_ack        = '0;
    step(2);
    rst = 1'b0;
    for (int c = 0; c < CNT; c++) expect_ch("reset", c, 0, 0, 0, 0, 0);
    expect_val("reset_irq", K_ANY, 0, 0);

    // Link-up latency: good first sampled now, link_up on the 17th cycle after.
    bus.cfg_enable = '1;
    step(16);
    expect_val("arm16_link_up", K_UP, 0, 0);
    expect_val("arm16_state", K_ST, 0, 1);
    step();
    expect_val("up17_link_up", K_UP, 0, 1);
    expect_val("up17_state", K_ST, 0, 2);
    expect_val("up17_irq_status", K_IRQ, 0, 1);
    expect_val("up17_irq", K_ANY, 0, 1);
    bus.irq_ack = '1;
    step();
    bus.irq_ack = '0;
    expect_val("ack_irq_status", K_IRQ, 0, 0);
    expect_val("ack_irq", K_ANY, 0, 0);

    // ch1 glitch of 3 cycles absorbed, then 5 bad cycles take it down.
    bus.rx_block_lock[1] = 1'b0;
    step();
    expect_val("glitch_hold_state", K_ST, 1, 3);
    expect_val("glitch_hold_up", K_UP, 1, 1);
    step(2);
    bus.rx_block_lock[1] = 1'b1;
    step();
    expect_ch("glitch_absorbed", 1, 1, 2, 0, 0, 0);
    expect_val("glitch_irq", K_ANY, 0, 0);
    bus.rx_block_lock[1] = 1'b0;
    step(5);
    expect_ch("drop5", 1, 0, 0, 1, 0, 1);
    expect_val("drop5_irq", K_ANY, 0, 1);
    bus.rx_block_lock[1] = 1'b1;
    step(17);
    expect_val("ch1_rearmed", K_UP, 1, 1);
    bus.irq_ack = '1;
    step();
    bus.irq_ack = '0;

    // ch2 forced down by disable, then arming aborted at timer 10.
    bus.cfg_enable[2] = 1'b0;
    step();
    expect_ch("disable_ch2", 2, 0, 0, 0, 0, 0);
    bus.cfg_enable[2] = 1'b1;
    step(10);
    expect_val("arm_t10", K_ST, 2, 1);
    bus.rx_block_lock[2] = 1'b0;
    step();
    expect_val("arm_abort", K_ST, 2, 0);
    bus.rx_block_lock[2] = 1'b1;
    step(16);
    expect_val("rearm16_up", K_UP, 2, 0);
    step();
    expect_val("rearm17_up", K_UP, 2, 1);
    expect_val("rearm17_irq", K_IRQ, 2, 1);

    // ch3 error accumulation with saturation and clear-wins.
    bus.rx_error_count[3] = 7'd100;
    step();
    expect_val("err_100", K_ERR, 3, 100);
    step();
    expect_val("err_200", K_ERR, 3, 200);
    step();
    expect_val("err_sat", K_ERR, 3, 255);
    bus.rx_error_count[3] = 7'd5;
    bus.clear_req[3]      = 1'b1;
    step();
    bus.clear_req[3]      = 1'b0;
    bus.rx_error_count[3] = 7'd0;
    expect_val("err_cleared", K_ERR, 3, 0);

    // ch0 flap counter saturates at 15; last flap has ack coincident with the down event.
    for (int i = 0; i < 20; i++) flap0(i == 19, i);

    bus.irq_ack = '1;
    step();
    bus.irq_ack = '0;
    bus.rx_error_count[3] = 7'd7;
    step();
    bus.rx_error_count[3] = 7'd0;
    bus.cfg_enable[1] = 1'b0;
    step();
    expect_ch("disable_up_ch1", 1, 0, 0, 1, 0, 0);
    expect_val("disable_irq", K_ANY, 0, 0);
    expect_val("err_7", K_ERR, 3, 7);
    bus.cfg_enable[1] = 1'b1;
    step(17);
    for (int c = 0; c < CNT; c++) expect_val("all_up", K_UP, c, 1);

    rst = 1'b1;
    step();
    for (int c = 0; c < CNT; c++) expect_ch("mid_reset", c, 0, 0, 0, 0, 0);
    expect_val("mid_reset_irq", K_ANY, 0, 0);
    rst = 1'b0;
    step(2);

    checks++;
    if (sb.size() == 0)
      passed++;
    else
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
